pool_sched: RTL

POOL_SCHED -- requirements
Module: pool_sched

---
 rtl/pool_pkg.sv | 17 +
 rtl/pool_sched_if.sv | 34 +++
 rtl/pool_cnt2d.sv | 40 ++++
 rtl/pool_sched.sv | 100 ++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared globals for the pooling block: default widths and the scheduler state type.
package pool_pkg;

    localparam int PSUM_WIDTH = 16;
    localparam int ADDR_W_DEF = 12;
    localparam int FRM_W_DEF  = 5;
    localparam int ROW_W_DEF  = 6;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        RD,
        DRAIN,
        DONE
    } pool_state_e;

endpackage

// File: rtl/pool_sched_if.sv
// Config and global-buffer read handshake between the pool scheduler and its environment.
interface pool_sched_if
    import pool_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FRM_W  = FRM_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
) ();

    logic              CFGPOOL_val;
    logic              POOLCFG_rdy;
    logic [ADDR_W-1:0] CFGPOOL_base_addr;
    logic [FRM_W-1:0]  CFGPOOL_num_frame;
    logic [ROW_W-1:0]  CFGPOOL_num_row;
    logic              CFGPOOL_valfrmpool;

    logic              POOLGB_rdy;
    logic [ADDR_W-1:0] POOLGB_addr;
    logic              GBPOOL_val;

    // master is the scheduler: it consumes config and issues GB reads
    modport master (
        input  CFGPOOL_val, CFGPOOL_base_addr, CFGPOOL_num_frame, CFGPOOL_num_row,
               CFGPOOL_valfrmpool, GBPOOL_val,
        output POOLCFG_rdy, POOLGB_rdy, POOLGB_addr
    );

    modport slave (
        output CFGPOOL_val, CFGPOOL_base_addr, CFGPOOL_num_frame, CFGPOOL_num_row,
               CFGPOOL_valfrmpool, GBPOOL_val,
        input  POOLCFG_rdy, POOLGB_rdy, POOLGB_addr
    );

endinterface

// File: rtl/pool_cnt2d.sv
// Row/frame counter pair: row wraps at num_row and carries into frame.
module pool_cnt2d
    import pool_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int FRM_W = FRM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [ROW_W-1:0] num_row,
    input  logic [FRM_W-1:0] num_frame,
    output logic [ROW_W-1:0] row,
    output logic [FRM_W-1:0] frame,
    output logic             row_last,
    output logic             frm_last
);

    assign row_last = (row == num_row);
    assign frm_last = (frame == num_frame);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row   <= '0;
            frame <= '0;
        end else if (clr) begin
            row   <= '0;
            frame <= '0;
        end else if (inc) begin
            if (row_last) begin
                row   <= '0;
                frame <= frame + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_sched.sv
// Pool scheduler: walks frame x row GB reads for one feature group and flags
// frame boundaries to the pooling datapath, with optional frame-pair pooling.
module pool_sched
    import pool_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FRM_W  = FRM_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    pool_sched_if.master bus,
    output logic         frm_first,
    output logic         frm_odd,
    output logic         row_last,
    output logic         emit,
    input  logic         pool_busy
);

    pool_state_e       state, nextState;
    logic [ADDR_W-1:0] baseAddr;
    logic [ROW_W-1:0]  numRow;
    logic [FRM_W-1:0]  numFrame;
    logic              vfp;
    logic [ROW_W-1:0]  row;
    logic [FRM_W-1:0]  frame;
    logic              rowLast, frmLast;
    logic              cfgAcc, beatAcc, inRd;
    logic [ADDR_W-1:0] frmStride, rdAddr;

    assign inRd    = (state == RD);
    assign cfgAcc  = (state == CFG) && bus.CFGPOOL_val;
    assign beatAcc = inRd && bus.GBPOOL_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baseAddr <= '0;
            numRow   <= '0;
            numFrame <= '0;
            vfp      <= 1'b0;
        end else begin
            state <= nextState;
            if (cfgAcc) begin
                baseAddr <= bus.CFGPOOL_base_addr;
                numRow   <= bus.CFGPOOL_num_row;
                numFrame <= bus.CFGPOOL_num_frame;
                vfp      <= bus.CFGPOOL_valfrmpool;
            end
        end
    end

    pool_cnt2d #(
        .ROW_W (ROW_W),
        .FRM_W (FRM_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cfgAcc),
        .inc       (beatAcc),
        .num_row   (numRow),
        .num_frame (numFrame),
        .row       (row),
        .frame     (frame),
        .row_last  (rowLast),
        .frm_last  (frmLast)
    );

    // All address arithmetic is done in ADDR_W bits so it wraps naturally.
    assign frmStride = ADDR_W'(frame) * (ADDR_W'(numRow) + ADDR_W'(1));
    assign rdAddr    = baseAddr + frmStride + ADDR_W'(row);

    assign bus.POOLCFG_rdy = (state == CFG);
    assign bus.POOLGB_rdy  = inRd;
    assign bus.POOLGB_addr = inRd ? rdAddr : '0;
    assign frm_first       = inRd && (frame == '0);
    assign frm_odd         = inRd && frame[0];
    assign row_last        = inRd && rowLast;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    // With pairing on, an unpaired final (even) frame still has to emit.
    assign emit = beatAcc && rowLast && (!vfp || frame[0] || frmLast);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start) nextState = CFG;
            CFG:     if (cfgAcc) nextState = RD;
            RD:      if (beatAcc && rowLast && frmLast) nextState = DRAIN;
            DRAIN:   if (!pool_busy) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

endmodule
